busy_stats_reporter: RTL and testbench

Downstream consumer of the GAM/gradient busy-cycle counters. On a snapshot request it captures both 128-bit counters in the same cycle and streams them out as a 9-word, 32-bit framed packet over a valid/ready interface toward the host readout path. Requests arriving while a frame is in flight are dropped and counted.

---
 rtl/busy_stats_pkg.sv | 34 +++
 rtl/busy_stats_snapshot.sv | 58 +++++
 rtl/busy_stats_reporter.sv | 106 ++++++++++
 tb/tb_busy_stats_reporter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busy_stats_pkg.sv
// Shared types and constants for the busy-counter snapshot reporter.
// Optional build macro: BUSY_STATS_DELTA_EN (see busy_stats_snapshot).
package busy_stats_pkg;

  localparam int WORD_W        = 32;
  localparam int FRAME_WORDS   = 9;
  localparam int PAYLOAD_WORDS = 8;

  localparam logic [7:0] HDR_LEN        = 8'(FRAME_WORDS);
  localparam logic [7:0] HDR_DELTA_FLAG = 8'h80;

  // Index of the final payload word; out_last rides on this one.
  localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Picks one 32-bit word out of a 128-bit counter, least significant first.
  function automatic logic [WORD_W-1:0] word_sel(input logic [127:0] value,
                                                 input logic [1:0]   idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = value[31:0];
      2'd1:    w = value[63:32];
      2'd2:    w = value[95:64];
      default: w = value[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/busy_stats_snapshot.sv
// Capture registers for the GAM and gradient busy counters.
// Build macro BUSY_STATS_DELTA_EN: when defined, the presented values are the
// modulo-2^128 difference from the previous snapshot instead of the absolute
// counts; when undefined no previous-value registers exist.
module busy_stats_snapshot
  import busy_stats_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         capture,
  input  logic [127:0] gam_in,
  input  logic [127:0] grad_in,
  output logic [127:0] gam_value,
  output logic [127:0] grad_value
);

  logic [127:0] gam_q;
  logic [127:0] grad_q;

`ifdef BUSY_STATS_DELTA_EN
  logic [127:0] gam_prev;
  logic [127:0] grad_prev;

  // Capture deltas and roll the previous-snapshot registers on the same edge.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; here the delta must see the old gam_prev.
    if (!reset_n) begin
      gam_q     <= '0;
      grad_q    <= '0;
      gam_prev  <= '0;
      grad_prev <= '0;
    end else if (capture) begin
      gam_q     <= gam_in - gam_prev;
      grad_q    <= grad_in - grad_prev;
      gam_prev  <= gam_in;
      grad_prev <= grad_in;
    end
  end
`else
  // Capture absolute counter values; held until the next capture.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      gam_q  <= '0;
      grad_q <= '0;
    end else if (capture) begin
      gam_q  <= gam_in;
      grad_q <= grad_in;
    end
  end
`endif

  assign gam_value  = gam_q;
  assign grad_value = grad_q;

endmodule

// File: rtl/busy_stats_reporter.sv
// Snapshots the GAM/gradient busy counters on request and streams them as a
// 9-word framed packet (header + 8 payload words) over valid/ready.
// Build macro BUSY_STATS_DELTA_EN selects delta payloads and flags the header.
module busy_stats_reporter
  import busy_stats_pkg::*;
#(
  parameter logic [15:0] HEADER_MAGIC = 16'hD1CE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              snap_req,
  input  logic [127:0]      gam_busy_counter,
  input  logic [127:0]      grad_busy_counter,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        drop_count
);

`ifdef BUSY_STATS_DELTA_EN
  localparam logic [7:0] HDR_LOW = HDR_LEN | HDR_DELTA_FLAG;
`else
  localparam logic [7:0] HDR_LOW = HDR_LEN;
`endif

  state_e       state;
  logic [2:0]   word_idx;
  logic [7:0]   seq;
  logic         capture;
  logic         handshake;
  logic [127:0] gam_value;
  logic [127:0] grad_value;

  // A request is only honoured when no frame is in flight.
  assign capture   = (state == IDLE) && snap_req;
  assign handshake = out_valid && out_ready;

  busy_stats_snapshot u_snapshot (
    .clock      (clock),
    .reset_n    (reset_n),
    .capture    (capture),
    .gam_in     (gam_busy_counter),
    .grad_in    (grad_busy_counter),
    .gam_value  (gam_value),
    .grad_value (grad_value)
  );

  // Frame sequencer: header, then eight payload words, advancing on handshake.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      word_idx <= '0;
      seq      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) state <= HEADER;
        end
        HEADER: begin
          if (handshake) begin
            state    <= PAYLOAD;
            word_idx <= '0;
            seq      <= seq + 8'd1;
          end
        end
        PAYLOAD: begin
          if (handshake) begin
            word_idx <= word_idx + 3'd1;
            if (word_idx == LAST_IDX) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count requests that arrive while a frame is in flight, saturating at 255.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (snap_req && (state != IDLE) && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Word mux; outputs derive from registered state and frozen snapshots, so
  // they stay put through a stall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    out_data = '0;
    case (state)
      HEADER:  out_data = {HEADER_MAGIC, seq, HDR_LOW};
      PAYLOAD: out_data = word_idx[2] ? word_sel(grad_value, word_idx[1:0])
                                      : word_sel(gam_value, word_idx[1:0]);
      default: out_data = '0;
    endcase
  end

  assign out_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign out_last  = (state == PAYLOAD) && (word_idx == LAST_IDX);

endmodule

// File: tb/tb_busy_stats_reporter.sv
// Scoreboard bench for busy_stats_reporter: stimulus pushes expected words,
// an independent monitor pops and compares on every accepted word.
module tb_busy_stats_reporter;

  localparam logic [15:0] MAGIC = 16'hD1CE;
`ifdef BUSY_STATS_DELTA_EN
  localparam logic [7:0] HDR_LOW_EXP = 8'h89;
`else
  localparam logic [7:0] HDR_LOW_EXP = 8'h09;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic         snap_req;
  logic [127:0] gam_busy_counter;
  logic [127:0] grad_busy_counter;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [7:0]   drop_count;

  int checks   = 0;
  int failures = 0;

  // Expected words: {last, data}.
  logic [32:0] exp_q[$];

  // Reference model state.
  logic [7:0]   m_seq;
  logic [127:0] m_prev_gam;
  logic [127:0] m_prev_grad;

  logic stall_mode = 1'b0;

  busy_stats_reporter #(.HEADER_MAGIC(MAGIC)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .snap_req          (snap_req),
    .gam_busy_counter  (gam_busy_counter),
    .grad_busy_counter (grad_busy_counter),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy),
    .drop_count        (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seq       = 8'd0;
    m_prev_gam  = '0;
    m_prev_grad = '0;
  endtask

  // Push the expected frame for a request the DUT will accept.
  task automatic push_frame(input logic [127:0] g, input logic [127:0] r);
    logic [127:0] pg;
    logic [127:0] pr;
`ifdef BUSY_STATS_DELTA_EN
    pg = g - m_prev_gam;
    pr = r - m_prev_grad;
    m_prev_gam  = g;
    m_prev_grad = r;
`else
    pg = g;
    pr = r;
`endif
    exp_q.push_back({1'b0, MAGIC, m_seq, HDR_LOW_EXP});
    m_seq = m_seq + 8'd1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, pg[32*i +: 32]});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), pr[32*i +: 32]});
  endtask

  // Ready driver: always ready, or the 1,0,0 repeating stall pattern.
  initial begin
    int k;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = stall_mode ? (k % 3 == 0) : 1'b1;
      k++;
    end
  end

  // Monitor: a word moves when valid&&ready at the coming edge.
  logic        prev_stall = 1'b0;
  logic [32:0] held;
  always @(negedge clock) begin
    logic [32:0] e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_word_held", {out_last, out_data}, held);
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {out_last, out_data}, 33'h1_DEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_data, e[31:0]);
          check("word_last", out_last, e[32]);
        end
      end
    end
  end

  // Wait (at posedge+1) until the frame is done; bounded.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (busy) check("wait_idle_timeout", busy, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Single-cycle request; caller sits at posedge+1 with the DUT idle.
  task automatic pulse_req();
    snap_req = 1'b1;
    @(posedge clock);
    #1;
    snap_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    snap_req          = 1'b0;
    gam_busy_counter  = '0;
    grad_busy_counter = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_count", drop_count, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic frame, ready held high; inputs changed after capture must not leak.
    gam_busy_counter  = 128'h1_00000002_00000003_00000004;
    grad_busy_counter = 128'h5;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    gam_busy_counter  = {4{32'hFFFF_0000}};
    grad_busy_counter = {4{32'h1234_5678}};
    repeat (8) @(posedge clock);
    #1;
    check("busy_before_last", busy, 1);
    @(posedge clock);
    #1;
    check("busy_after_last", busy, 0);
    check("valid_after_last", out_valid, 0);
    wait_drain();

    // Same content under the 1,0,0 ready pattern.
    gam_busy_counter  = 128'h1_00000002_00000003_00000004;
    grad_busy_counter = 128'h5;
    stall_mode = 1'b1;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    wait_idle();
    wait_drain();
    stall_mode = 1'b0;

    // Back-to-back frames; 256 of them carry the sequence byte through a wrap.
    for (int f = 0; f < 256; f++) begin
      gam_busy_counter  = {32'(f), 32'(f + 1), 32'(f + 2), 32'(f + 3)};
      grad_busy_counter = ~gam_busy_counter;
      push_frame(gam_busy_counter, grad_busy_counter);
      pulse_req();
      wait_idle();
    end
    wait_drain();
    check("no_drops_yet", drop_count, 0);

    // Request held for 20 edges: two frames accepted, 18 drops.
    gam_busy_counter  = 128'hA;
    grad_busy_counter = 128'hB;
    push_frame(gam_busy_counter, grad_busy_counter);
    push_frame(gam_busy_counter, grad_busy_counter);
    snap_req = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    snap_req = 1'b0;
    wait_idle();
    wait_drain();
    check("drop_count_held20", drop_count, 18);

    // Held for 300 edges: 30 frames, 270 more drops, saturates at 255.
    for (int f = 0; f < 30; f++) push_frame(gam_busy_counter, grad_busy_counter);
    snap_req = 1'b1;
    repeat (300) @(posedge clock);
    #1;
    snap_req = 1'b0;
    wait_idle();
    wait_drain();
    check("drop_count_saturated", drop_count, 255);

    // Reset while payload word 4 is presented.
    gam_busy_counter  = 128'h11;
    grad_busy_counter = 128'h22;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    repeat (5) @(posedge clock);
    #1;
    check("words_before_reset", exp_q.size(), 4);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_drop_count", drop_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    exp_q.delete();
    model_reset();
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    gam_busy_counter  = 128'h3333_0000_0000_0000_0000_0000_0000_0007;
    grad_busy_counter = 128'h9;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    wait_idle();
    wait_drain();

    // Delta-mode vectors (absolute frames when the feature is off).
    gam_busy_counter  = 128'd10;
    grad_busy_counter = 128'd0;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    wait_idle();
    gam_busy_counter = 128'd25;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    wait_idle();
    gam_busy_counter = '1 - 128'd2;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    wait_idle();
    gam_busy_counter = 128'd4;
    push_frame(gam_busy_counter, grad_busy_counter);
    pulse_req();
    wait_idle();
    wait_drain();

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
